// File: rtl/dmg_bus_pkg.sv
// dmg_bus_pkg.sv - shared types and constants for the SM83 bus arbiter and OAM DMA sequencer
package dmg_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XRD   = 2'd2,
        XWR   = 2'd3
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [7:0]  OAM_HI       = 8'hFE;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [7:0]  CPU_OPEN_BUS = 8'hFF;

endpackage

// File: rtl/oam_dma_seq.sv
// oam_dma_seq.sv - OAM DMA sequencer: start delay, read/write byte pairs, data latch
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   start_i          register write seen this cycle; restarts the copy from byte 0
//   src_i            source page (high address byte)
//   stall_i          CPU owns the bus this cycle; hold all sequencer state
//   rdata_i          memory read data, captured at the end of an XRD cycle
//   req_o/rd_o/wr_o  requested memory-side strobes
//   addr_o, data_o   requested memory-side address and write data
//   active_o         copy in progress (any state other than IDLE)
module oam_dma_seq
    import dmg_bus_pkg::*;
#(
    parameter logic [7:0] DST_HI      = 8'hFE,
    parameter int         LENGTH      = 160,
    parameter int         START_DELAY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  src_i,
    input  logic        stall_i,
    input  logic [7:0]  rdata_i,
    output logic        req_o,
    output logic        rd_o,
    output logic        wr_o,
    output logic [15:0] addr_o,
    output logic [7:0]  data_o,
    output logic        active_o
);

    localparam int         CW       = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [CW-1:0] DLY_INIT = CW'(START_DELAY - 1);
    // idx is 8 bits wide, so LENGTH=256 finishes at 8'hFF and idx wraps to 0
    localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

    dma_state_t    state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    latch_q, latch_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= 8'h00;
            cnt_q   <= '0;
            latch_q <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        latch_d = latch_q;
        req_o   = 1'b0;
        rd_o    = 1'b0;
        wr_o    = 1'b0;
        addr_o  = 16'h0000;
        data_o  = 8'h00;

        case (state_q)
            IDLE: ;
            START: begin
                if (!stall_i) begin
                    if (cnt_q == '0) begin
                        state_d = XRD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            XRD: begin
                req_o  = 1'b1;
                rd_o   = 1'b1;
                addr_o = {src_i, idx_q};
                if (!stall_i) begin
                    latch_d = rdata_i;
                    state_d = XWR;
                end
            end
            XWR: begin
                req_o  = 1'b1;
                wr_o   = 1'b1;
                addr_o = {DST_HI, idx_q};
                data_o = latch_q;
                if (!stall_i) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == LAST_IDX) ? IDLE : XRD;
                end
            end
            default: state_d = IDLE;
        endcase

        // A register write restarts the copy regardless of the current state
        if (start_i) begin
            state_d = START;
            idx_d   = 8'h00;
            cnt_d   = DLY_INIT;
        end
    end

    assign active_o = (state_q != IDLE);

endmodule

// File: rtl/oam_dma_bus_arbiter.sv
// oam_dma_bus_arbiter.sv - shares the SM83 memory bus between the core and the OAM DMA engine
//
// Ports:
//   CLK, nRESET                     clock, asynchronous active-low reset
//   CPU_MREQ/RD/WR, CPU_A, CPU_DO   core-side request
//   CPU_DI                          read data returned to the core
//   MREQ/RD/WR, A, DO               memory-side request
//   DI                              memory-side read data (same cycle)
//   DMA_ACTIVE                      copy in progress
module oam_dma_bus_arbiter #(
    parameter logic [15:0] REG_ADDR    = dmg_bus_pkg::DMA_REG_ADDR,
    parameter logic [7:0]  DST_HI      = dmg_bus_pkg::OAM_HI,
    parameter int          LENGTH      = 160,
    parameter int          START_DELAY = 1,
    parameter logic [15:0] HRAM_LO     = dmg_bus_pkg::HRAM_LO
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        CPU_MREQ,
    input  logic        CPU_RD,
    input  logic        CPU_WR,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_DO,
    output logic [7:0]  CPU_DI,
    output logic        MREQ,
    output logic        RD,
    output logic        WR,
    output logic [15:0] A,
    output logic [7:0]  DO,
    input  logic [7:0]  DI,
    output logic        DMA_ACTIVE
);
    import dmg_bus_pkg::*;

    logic [7:0]  src_reg_q, src_reg_d;
    logic        reg_hit, reg_wr, hram_hit, stall;
    logic        dma_req, dma_rd, dma_wr;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;

    assign reg_hit  = CPU_MREQ && (CPU_A == REG_ADDR);
    assign reg_wr   = reg_hit && CPU_WR;
    assign hram_hit = CPU_MREQ && (CPU_A >= HRAM_LO) && !reg_hit;
    assign stall    = DMA_ACTIVE && hram_hit;
    assign src_reg_d = reg_wr ? CPU_DO : src_reg_q;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            src_reg_q <= 8'h00;
        end else begin
            src_reg_q <= src_reg_d;
        end
    end

    oam_dma_seq #(
        .DST_HI      (DST_HI),
        .LENGTH      (LENGTH),
        .START_DELAY (START_DELAY)
    ) u_seq (
        .clk_i    (CLK),
        .rst_ni   (nRESET),
        .start_i  (reg_wr),
        .src_i    (src_reg_q),
        .stall_i  (stall),
        .rdata_i  (DI),
        .req_o    (dma_req),
        .rd_o     (dma_rd),
        .wr_o     (dma_wr),
        .addr_o   (dma_addr),
        .data_o   (dma_data),
        .active_o (DMA_ACTIVE)
    );

    // Bus mux. Outputs are gated by nRESET directly so an abort takes the bus
    // away in the same cycle rather than at the next edge.
    always_comb begin
        MREQ = 1'b0;
        RD   = 1'b0;
        WR   = 1'b0;
        A    = 16'h0000;
        DO   = 8'h00;
        if (nRESET) begin
            if (reg_hit) begin
                // Register accesses never reach memory; a register read during
                // a copy leaves the bus to the DMA, a register write suppresses
                // whatever the DMA would have issued this cycle.
                if (DMA_ACTIVE && !reg_wr) begin
                    MREQ = dma_req;
                    RD   = dma_rd;
                    WR   = dma_wr;
                    A    = dma_addr;
                    DO   = dma_data;
                end
            end else if (!DMA_ACTIVE || hram_hit) begin
                MREQ = CPU_MREQ;
                RD   = CPU_RD;
                WR   = CPU_WR;
                A    = CPU_A;
                DO   = CPU_DO;
            end else begin
                MREQ = dma_req;
                RD   = dma_rd;
                WR   = dma_wr;
                A    = dma_addr;
                DO   = dma_data;
            end
        end
    end

    always_comb begin
        CPU_DI = CPU_OPEN_BUS;
        if (nRESET) begin
            if (reg_hit && CPU_RD) begin
                CPU_DI = src_reg_q;
            end else if (CPU_MREQ && CPU_RD && (!DMA_ACTIVE || hram_hit)) begin
                CPU_DI = DI;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
// tb_oam_dma_bus_arbiter.sv - directed self-checking bench for oam_dma_bus_arbiter
module tb_oam_dma_bus_arbiter;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        CPU_MREQ, CPU_RD, CPU_WR;
    logic [15:0] CPU_A;
    logic [7:0]  CPU_DO;
    logic [7:0]  CPU_DI;
    logic        MREQ, RD, WR;
    logic [15:0] A;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        DMA_ACTIVE;

    int total = 0;
    int bad   = 0;

    int          act_cnt;
    logic [15:0] rq[$];
    logic [15:0] wq_a[$];
    logic [7:0]  wq_d[$];
    logic [7:0]  oam[0:255];

    oam_dma_bus_arbiter dut (
        .CLK(CLK), .nRESET(nRESET),
        .CPU_MREQ(CPU_MREQ), .CPU_RD(CPU_RD), .CPU_WR(CPU_WR),
        .CPU_A(CPU_A), .CPU_DO(CPU_DO), .CPU_DI(CPU_DI),
        .MREQ(MREQ), .RD(RD), .WR(WR), .A(A), .DO(DO), .DI(DI),
        .DMA_ACTIVE(DMA_ACTIVE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        if (a == 16'h1234)       return 8'h5A;
        if (a[15:8] == 8'hC0)    return a[7:0];
        if (a[15:8] == 8'hD0)    return a[7:0] ^ 8'h5A;
        if (a == 16'hFF90)       return 8'h77;
        return 8'h00;
    endfunction

    assign DI = (MREQ && RD) ? mem_rd(A) : 8'h00;

    always @(negedge CLK) begin
        if (nRESET) begin
            if (DMA_ACTIVE) act_cnt++;
            if (MREQ && RD && (A[15:8] == 8'hC0 || A[15:8] == 8'hD0)) rq.push_back(A);
            if (MREQ && WR) begin
                wq_a.push_back(A);
                wq_d.push_back(DO);
                if (A[15:8] == 8'hFE) oam[A[7:0]] = DO;
            end
        end
    end

    task automatic cpu_idle();
        CPU_MREQ = 1'b0; CPU_RD = 1'b0; CPU_WR = 1'b0; CPU_A = 16'h0000; CPU_DO = 8'h00;
    endtask

    task automatic clear_log();
        rq.delete(); wq_a.delete(); wq_d.delete();
        act_cnt = 0;
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    endtask

    task automatic reg_write(input logic [7:0] v);
        @(posedge CLK); #1;
        CPU_MREQ = 1'b1; CPU_WR = 1'b1; CPU_RD = 1'b0; CPU_A = 16'hFF46; CPU_DO = v;
        @(posedge CLK); #1;
        cpu_idle();
    endtask

    task automatic wait_idle(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!DMA_ACTIVE) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        CPU_MREQ = 1'b1; CPU_RD = 1'b1; CPU_WR = 1'b0; CPU_A = 16'h1234; CPU_DO = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (MREQ !== 1'b0) begin bad++; $display("FAIL reset_mreq got=%b exp=0", MREQ); end
        total++; if ({RD, WR} !== 2'b00) begin bad++; $display("FAIL reset_rdwr got=%b exp=00", {RD, WR}); end
        total++; if (A !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", A); end
        total++; if (DMA_ACTIVE !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", DMA_ACTIVE); end
        total++; if (CPU_DI !== 8'hFF) begin bad++; $display("FAIL reset_cpu_di got=%h exp=ff", CPU_DI); end
        nRESET = 1'b1;
        #1;
        total++; if (A !== 16'h1234) begin bad++; $display("FAIL pass_addr got=%h exp=1234", A); end
        total++; if ({MREQ, RD} !== 2'b11) begin bad++; $display("FAIL pass_strobes got=%b exp=11", {MREQ, RD}); end
        total++; if (CPU_DI !== 8'h5A) begin bad++; $display("FAIL pass_cpu_di got=%h exp=5a", CPU_DI); end
        @(posedge CLK); #1;
        cpu_idle();
    endtask

    task automatic test_full_copy();
        bit tmo;
        int errs;
        clear_log();
        reg_write(8'hC0);
        wait_idle(tmo);
        total++; if (tmo) begin bad++; $display("FAIL copy_timeout active=%b exp=0", DMA_ACTIVE); end
        total++; if (act_cnt !== 321) begin bad++; $display("FAIL copy_active_cycles got=%0d exp=321", act_cnt); end
        total++; if (wq_a.size() !== 160 || rq.size() !== 160) begin bad++;
            $display("FAIL copy_counts writes=%0d reads=%0d exp=160/160", wq_a.size(), rq.size()); end
        errs = 0;
        for (int k = 0; k < 160; k++) begin
            if (k < wq_a.size() && (wq_a[k] !== (16'hFE00 + 16'(k)) || wq_d[k] !== 8'(k))) errs++;
            if (k < rq.size() && rq[k] !== (16'hC000 + 16'(k))) errs++;
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL copy_order errors=%0d exp=0", errs); end
        CPU_MREQ = 1'b1; CPU_RD = 1'b1; CPU_A = 16'hFF46;
        #1;
        total++; if (CPU_DI !== 8'hC0) begin bad++; $display("FAIL reg_read got=%h exp=c0", CPU_DI); end
        total++; if (MREQ !== 1'b0) begin bad++; $display("FAIL reg_read_fwd mreq=%b exp=0", MREQ); end
        @(posedge CLK); #1;
        cpu_idle();
    endtask

    task automatic test_blocked_cpu();
        bit tmo;
        int errs;
        clear_log();
        reg_write(8'hC0);
        repeat (20) @(posedge CLK);
        #1;
        CPU_MREQ = 1'b1; CPU_RD = 1'b1; CPU_A = 16'hC123;
        #1;
        total++; if (CPU_DI !== 8'hFF) begin bad++; $display("FAIL blocked_read got=%h exp=ff", CPU_DI); end
        total++; if (A === 16'hC123) begin bad++; $display("FAIL blocked_read_fwd addr=%h exp=dma", A); end
        @(posedge CLK); #1;
        CPU_RD = 1'b0; CPU_WR = 1'b1; CPU_A = 16'hC000; CPU_DO = 8'hAA;
        @(posedge CLK); #1;
        cpu_idle();
        wait_idle(tmo);
        total++; if (tmo) begin bad++; $display("FAIL blocked_timeout active=%b exp=0", DMA_ACTIVE); end
        total++; if (act_cnt !== 321) begin bad++; $display("FAIL blocked_active_cycles got=%0d exp=321", act_cnt); end
        errs = 0;
        foreach (wq_a[i]) if (wq_a[i] === 16'hC000) errs++;
        total++; if (errs !== 0) begin bad++; $display("FAIL blocked_write_fwd count=%0d exp=0", errs); end
        errs = 0;
        for (int k = 0; k < 160; k++) if (oam[k] !== 8'(k)) errs++;
        total++; if (errs !== 0) begin bad++; $display("FAIL blocked_oam errors=%0d exp=0", errs); end
    endtask

    task automatic test_hram_priority();
        bit tmo;
        int errs, n0;
        clear_log();
        reg_write(8'hC0);
        repeat (30) @(posedge CLK);
        #1;
        n0 = rq.size() + wq_a.size();
        for (int c = 0; c < 3; c++) begin
            CPU_MREQ = 1'b1; CPU_RD = 1'b1; CPU_A = 16'hFF90;
            #1;
            total++; if (CPU_DI !== 8'h77 || A !== 16'hFF90) begin bad++;
                $display("FAIL hram_read cycle=%0d di=%h addr=%h exp=77/ff90", c, CPU_DI, A); end
            @(posedge CLK); #1;
        end
        cpu_idle();
        total++; if (rq.size() + wq_a.size() !== n0) begin bad++;
            $display("FAIL hram_freeze dma_accesses=%0d exp=%0d", rq.size() + wq_a.size(), n0); end
        wait_idle(tmo);
        total++; if (tmo) begin bad++; $display("FAIL hram_timeout active=%b exp=0", DMA_ACTIVE); end
        total++; if (act_cnt !== 324) begin bad++; $display("FAIL hram_active_cycles got=%0d exp=324", act_cnt); end
        errs = 0;
        for (int k = 0; k < 160; k++) if (oam[k] !== 8'(k)) errs++;
        total++; if (errs !== 0 || wq_a.size() !== 160) begin bad++;
            $display("FAIL hram_oam errors=%0d writes=%0d exp=0/160", errs, wq_a.size()); end
    endtask

    task automatic test_restart();
        bit tmo;
        int errs, dreads;
        clear_log();
        reg_write(8'hC0);
        repeat (49) @(posedge CLK);
        #1;
        CPU_MREQ = 1'b1; CPU_WR = 1'b1; CPU_A = 16'hFF46; CPU_DO = 8'hD0;
        @(posedge CLK); #1;
        cpu_idle();
        act_cnt = 0;
        wait_idle(tmo);
        total++; if (tmo) begin bad++; $display("FAIL restart_timeout active=%b exp=0", DMA_ACTIVE); end
        total++; if (act_cnt !== 321) begin bad++; $display("FAIL restart_active_cycles got=%0d exp=321", act_cnt); end
        dreads = 0;
        foreach (rq[i]) if (rq[i][15:8] === 8'hD0) dreads++;
        total++; if (dreads !== 160) begin bad++; $display("FAIL restart_dreads got=%0d exp=160", dreads); end
        errs = 0;
        for (int k = 0; k < 160; k++) if (oam[k] !== (8'(k) ^ 8'h5A)) errs++;
        total++; if (errs !== 0) begin bad++; $display("FAIL restart_oam errors=%0d exp=0", errs); end
    endtask

    task automatic test_abort();
        bit found;
        clear_log();
        reg_write(8'hC0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (WR === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(posedge CLK); #1;
        end
        total++; if (!found) begin bad++; $display("FAIL abort_find_xwr got=none exp=xwr"); end
        nRESET = 1'b0;
        #1;
        total++; if ({MREQ, RD, WR} !== 3'b000 || A !== 16'h0000 || DO !== 8'h00) begin bad++;
            $display("FAIL abort_bus strobes=%b addr=%h do=%h exp=000/0000/00", {MREQ, RD, WR}, A, DO); end
        total++; if (DMA_ACTIVE !== 1'b0) begin bad++; $display("FAIL abort_active got=%b exp=0", DMA_ACTIVE); end
        @(posedge CLK); #1;
        nRESET = 1'b1;
        clear_log();
        repeat (400) @(posedge CLK);
        #1;
        total++; if (rq.size() + wq_a.size() !== 0 || DMA_ACTIVE !== 1'b0) begin bad++;
            $display("FAIL abort_quiet accesses=%0d active=%b exp=0/0", rq.size() + wq_a.size(), DMA_ACTIVE); end
        CPU_MREQ = 1'b1; CPU_RD = 1'b1; CPU_A = 16'hFF46;
        #1;
        total++; if (CPU_DI !== 8'h00) begin bad++; $display("FAIL abort_src_reg got=%h exp=00", CPU_DI); end
        @(posedge CLK); #1;
        cpu_idle();
    endtask

    initial begin
        act_cnt = 0;
        cpu_idle();
        test_reset();
        test_full_copy();
        test_blocked_cpu();
        test_hram_priority();
        test_restart();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
